// File: rtl/apa102_defs.sv
// rtl/apa102_defs.sv - shared constants, pixel field offsets and FSM encoding for the APA102 streamer
package apa102_defs;

    localparam logic [2:0] APA102_HDR       = 3'b111;
    localparam int         START_FRAME_BITS = 32;
    localparam int         LED_FRAME_BITS   = 32;

    localparam int PIX_R_MSB = 23;
    localparam int PIX_R_LSB = 16;
    localparam int PIX_G_MSB = 15;
    localparam int PIX_G_LSB = 8;
    localparam int PIX_B_MSB = 7;
    localparam int PIX_B_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        START_FRM,
        FETCH_ADDR,
        FETCH_WAIT,
        LED_FRM,
        END_FRM
    } state_t;

    // End frame must supply at least one clock edge per two LEDs, in whole bytes, never under 32.
    function automatic int end_frame_bits(input int num_leds);
        int half_leds;
        int rounded;
        half_leds = (num_leds + 1) / 2;
        rounded   = ((half_leds + 7) / 8) * 8;
        return (rounded > 32) ? rounded : 32;
    endfunction

endpackage

// File: rtl/apa102_word_shifter.sv
// rtl/apa102_word_shifter.sv - serialises one loaded word MSB first with CLK_DIV-cycle SCK phases
module apa102_word_shifter #(
    parameter int CLK_DIV = 4,
    parameter int BITS_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [31:0]       load_word,
    input  logic [BITS_W-1:0] load_bits,
    output logic              spi_sck,
    output logic              spi_mosi,
    output logic              word_done
);

    localparam int              PH_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);

    logic [31:0]       shreg;
    logic [PH_W-1:0]   phase;
    logic [BITS_W-1:0] bits_left;
    logic              active;
    logic              phase_end;

    assign phase_end = active && (phase == PH_LAST);
    assign word_done = phase_end && spi_sck && (bits_left == BITS_W'(1));

    // Ones are shifted in so words longer than 32 bits (the end frame) stay all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            phase     <= '0;
            bits_left <= '0;
            active    <= 1'b0;
            spi_sck   <= 1'b0;
            spi_mosi  <= 1'b0;
        end else if (load) begin
            shreg     <= load_word;
            spi_mosi  <= load_word[31];
            bits_left <= load_bits;
            phase     <= '0;
            spi_sck   <= 1'b0;
            active    <= 1'b1;
        end else if (active) begin
            if (!phase_end) begin
                phase <= phase + 1'b1;
            end else begin
                phase <= '0;
                if (!spi_sck) begin
                    spi_sck <= 1'b1;
                end else begin
                    spi_sck <= 1'b0;
                    if (bits_left == BITS_W'(1)) begin
                        active <= 1'b0;
                    end else begin
                        shreg     <= {shreg[30:0], 1'b1};
                        spi_mosi  <= shreg[30];
                        bits_left <= bits_left - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/apa102_frame_streamer.sv
// rtl/apa102_frame_streamer.sv - reads the pixel RAM and emits one APA102 frame per start; optional APA102_RUNTIME_BRIGHTNESS_EN
module apa102_frame_streamer
    import apa102_defs::*;
#(
    parameter int         NUM_LEDS   = 64,
    parameter int         CLK_DIV    = 4,
    parameter logic [4:0] BRIGHTNESS = 5'd31
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
`ifdef APA102_RUNTIME_BRIGHTNESS_EN
    input  logic [4:0]                  brightness,
`endif
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(NUM_LEDS)-1:0] ram_address,
    input  logic [23:0]                 ram_read_data,
    output logic                        spi_sck,
    output logic                        spi_mosi
);

    localparam int            IDX_W    = $clog2(NUM_LEDS);
    localparam int            END_BITS = end_frame_bits(NUM_LEDS);
    localparam int            BITS_W   = $clog2(END_BITS + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LEDS - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              done_q, done_d;
    logic              accept;
    logic [4:0]        bri;
    logic              shift_load;
    logic [31:0]       shift_word;
    logic [BITS_W-1:0] shift_bits;
    logic              word_done;

    // A start coinciding with the done pulse is dropped so back-to-back frames are spaced by one cycle.
    assign accept      = (state_q == IDLE) && start && !done_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign ram_address = idx_q;

`ifdef APA102_RUNTIME_BRIGHTNESS_EN
    logic [4:0] bri_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bri_q <= '0;
        end else if (accept) begin
            bri_q <= brightness;
        end
    end

    assign bri = bri_q;
`else
    assign bri = BRIGHTNESS;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        done_d     = 1'b0;
        shift_load = 1'b0;
        shift_word = '0;
        shift_bits = BITS_W'(LED_FRAME_BITS);
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = START_FRM;
                    shift_load = 1'b1;
                    shift_bits = BITS_W'(START_FRAME_BITS);
                end
            end
            START_FRM: begin
                if (word_done) begin
                    state_d = FETCH_ADDR;
                    idx_d   = '0;
                end
            end
            FETCH_ADDR: begin
                state_d = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                state_d    = LED_FRM;
                shift_load = 1'b1;
                shift_word = {APA102_HDR, bri,
                              ram_read_data[PIX_B_MSB:PIX_B_LSB],
                              ram_read_data[PIX_G_MSB:PIX_G_LSB],
                              ram_read_data[PIX_R_MSB:PIX_R_LSB]};
            end
            LED_FRM: begin
                if (word_done) begin
                    if (idx_q == IDX_LAST) begin
                        state_d    = END_FRM;
                        shift_load = 1'b1;
                        shift_word = '1;
                        shift_bits = BITS_W'(END_BITS);
                    end else begin
                        state_d = FETCH_ADDR;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            END_FRM: begin
                if (word_done) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    apa102_word_shifter #(
        .CLK_DIV (CLK_DIV),
        .BITS_W  (BITS_W)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (shift_load),
        .load_word (shift_word),
        .load_bits (shift_bits),
        .spi_sck   (spi_sck),
        .spi_mosi  (spi_mosi),
        .word_done (word_done)
    );

endmodule

// File: tb/tb_apa102_frame_streamer.sv
// tb/tb_apa102_frame_streamer.sv - randomized frame checks against a byte-level APA102 frame model
module tb_apa102_frame_streamer;

    localparam int         N    = 4;
    localparam int         CD   = 2;
    localparam logic [4:0] BR   = 5'd21;
    localparam int         AW   = $clog2(N);
    localparam int         HALF = (N + 1) / 2;
    localparam int         RND  = ((HALF + 7) / 8) * 8;
    localparam int         EB   = (RND > 32) ? RND : 32;
    localparam int         LAT  = 1 + 2 * CD * (32 + 32 * N + EB) + 2 * N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
`ifdef APA102_RUNTIME_BRIGHTNESS_EN
    logic [4:0]    brightness = 5'd0;
`endif
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_address;
    logic [23:0]   ram_read_data = '0;
    logic          spi_sck;
    logic          spi_mosi;

    logic [23:0]   mem [N];
    logic [7:0]    exp_q [$];
    bit            cap_q [$];
    int            sck_rises = 0;
    int            cyc = 0;
    int            n_vec = 0;
    int            n_err = 0;

    apa102_frame_streamer #(
        .NUM_LEDS   (N),
        .CLK_DIV    (CD),
        .BRIGHTNESS (BR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
`ifdef APA102_RUNTIME_BRIGHTNESS_EN
        .brightness    (brightness),
`endif
        .busy          (busy),
        .done          (done),
        .ram_address   (ram_address),
        .ram_read_data (ram_read_data),
        .spi_sck       (spi_sck),
        .spi_mosi      (spi_mosi)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_read_data <= mem[ram_address];
        cyc++;
    end

    always @(posedge spi_sck) begin
        cap_q.push_back(spi_mosi);
        sck_rises++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic build_expected(input logic [4:0] b);
        exp_q.delete();
        repeat (4) exp_q.push_back(8'h00);
        for (int i = 0; i < N; i++) begin
            exp_q.push_back({3'b111, b});
            exp_q.push_back(mem[i][7:0]);
            exp_q.push_back(mem[i][15:8]);
            exp_q.push_back(mem[i][23:16]);
        end
        repeat (EB / 8) exp_q.push_back(8'hFF);
    endtask

    task automatic compare_frame();
        logic [7:0] g;
        check("bit_count", cap_q.size(), 8 * exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            g = 'x;
            if (8 * i + 7 < cap_q.size())
                for (int j = 0; j < 8; j++) g = {g[6:0], cap_q[8 * i + j]};
            check($sformatf("byte%0d", i), g, exp_q[i]);
        end
    endtask

    // Caller is at a negedge; start is raised in this cycle.
    task automatic do_frame(input int mid_start, input bit start_on_done);
        int   a;
        int   b;
        bit   found;
        logic [4:0] bri_exp;
`ifdef APA102_RUNTIME_BRIGHTNESS_EN
        brightness = 5'($urandom);
        bri_exp    = brightness;
`else
        bri_exp    = BR;
`endif
        build_expected(bri_exp);
        cap_q.delete();
        start = 1'b1;
        a     = cyc;
        found = 1'b0;
        for (int k = 0; k < LAT + 50; k++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
            start = (k == mid_start);
`ifdef APA102_RUNTIME_BRIGHTNESS_EN
            if (k == LAT / 3) brightness = ~brightness;
`endif
        end
        b     = cyc;
        start = 1'b0;
        check("done_seen", found, 1);
        check("latency", b - a, LAT);
        check("busy_at_done", busy, 0);
        if (start_on_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_width", done, 0);
        check("busy_after_done", busy, 0);
        compare_frame();
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < N; i++) mem[i] = 24'($urandom);
    endtask

    initial begin
        int r0;
        for (int i = 0; i < N; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sck", spi_sck, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_addr", ram_address, 0);
        rst_n = 1'b1;
        r0 = sck_rises;
        repeat (100) @(negedge clk);
        check("idle_sck_edges", sck_rises - r0, 0);
        check("idle_busy", busy, 0);

        mem[0] = 24'hFF0000;
        mem[1] = 24'h0000FF;
        mem[2] = 24'h00FF00;
        mem[3] = 24'h123456;
        do_frame(-1, 1'b0);

        for (int i = 0; i < N; i++) mem[i] = 24'h010203 * (i + 1);
        do_frame(LAT / 2, 1'b1);
        do_frame(-1, 1'b0);

        repeat (3) begin
            randomize_mem();
            repeat ($urandom_range(1, 5)) @(negedge clk);
            do_frame($urandom_range(10, LAT - 10), 1'b0);
        end

        randomize_mem();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2 * CD * 32 + 2 + 2 * CD * 32 + 2 + 20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_sck", spi_sck, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        r0 = sck_rises;
        repeat (20) @(negedge clk);
        check("abort_no_resume_busy", busy, 0);
        check("abort_no_resume_sck", sck_rises - r0, 0);
        check("abort_no_done", done, 0);
        do_frame(-1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/apa102_frame_streamer.md
Name: apa102_frame_streamer

Overview:
Downstream consumer of the single-port pixel frame-buffer RAM.
- On `start`, walks RAM addresses 0..NUM_LEDS-1 and absorbs the RAM's 1-cycle read latency.
- Serialises one complete APA102 frame (start frame, LED frames, end frame) onto the SPI-like pixel strip pins.
- Sits between the frame buffer and the output pads; the RAM write side stays with the HDMI capture path.

Parameters:
- NUM_LEDS, 64: LEDs in the strip, which is also the RAM depth read. Must be ≥2.
- CLK_DIV, 4: clk cycles per SCK phase, so one bit = 2*CLK_DIV cycles. Must be ≥1.
- BRIGHTNESS, 31: 5-bit global brightness placed in each LED header.
- Derived localparam END_BITS = max(32, ceil(NUM_LEDS/2) rounded up to a multiple of 8).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to send a frame; ignored while busy
- busy  out  1  high while a frame is in progress
- done  out  1  one-cycle pulse when a frame completes
- ram_address  out  $clog2(NUM_LEDS)  read address to the frame buffer
- ram_read_data  in  24  pixel {R[23:16],G[15:8],B[7:0]}, valid 1 cycle after ram_address
- spi_sck  out  1  strip clock, idle low
- spi_mosi  out  1  strip data, MSB first

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: busy=0, done=0, ram_address=0, spi_sck=0, spi_mosi=0, FSM=IDLE. Reset mid-frame aborts immediately with no done pulse. A frame resumes only after a new start.
- FSM states: IDLE, START_FRM, FETCH_ADDR, FETCH_WAIT, LED_FRM, END_FRM.
  - IDLE: on start=1, go to START_FRM and load a 32-bit all-zero word.
  - START_FRM: shift 32 bits, then go to FETCH_ADDR with led index=0.
  - FETCH_ADDR: drive ram_address=index for 1 cycle, then go to FETCH_WAIT.
  - FETCH_WAIT: latch ram_read_data. Load word {3'b111, BRIGHTNESS[4:0], B, G, R}, then go to LED_FRM.
  - LED_FRM: shift 32 bits. If index==NUM_LEDS-1, go to END_FRM and load END_BITS ones. Otherwise increment index and go to FETCH_ADDR.
  - END_FRM: shift END_BITS bits, then go to IDLE.
- Bit timing, per bit:
  - spi_mosi is updated at bit start while spi_sck=0.
  - spi_sck stays low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - The strip samples on the rising edge.
  - spi_sck returns low at the end of the last bit of each word.
- Fetch gap: the 2 fetch cycles between LED words hold spi_sck=0 and spi_mosi stable. No SCK edges occur in the gap.
- ram_address holds its last value outside FETCH_ADDR. The RAM read is harmless, and this block never writes the RAM.
- busy goes high the cycle after start is accepted. It stays high until the cycle the FSM re-enters IDLE.
- done pulses for exactly 1 cycle on re-entry to IDLE, simultaneous with busy falling.
- Back-to-back frames: start asserted in the same cycle as done is ignored; start is accepted one cycle after done.
- Cycle count from start to done, for CLK_DIV=c: 1 + 2c*(32 + 32*NUM_LEDS + END_BITS) + 2*NUM_LEDS.
- Index counter width is $clog2(NUM_LEDS). Its wrap is never exercised, because the terminal compare stops it at NUM_LEDS-1.

Optional Feature:
APA102_RUNTIME_BRIGHTNESS_EN
- Defined: adds input port `brightness [4:0]`, sampled into a register when start is accepted. That register replaces the BRIGHTNESS parameter in the LED headers for the whole frame; a change mid-frame has no effect until the next frame.
- Undefined: no port; the BRIGHTNESS parameter is used as a constant.

Decomposition:
- Shared include/package apa102_defs:
  - APA102_HDR = 3'b111
  - START_FRAME_BITS = 32
  - LED_FRAME_BITS = 32
  - FSM state encodings
  - pixel field offsets R=23:16, G=15:8, B=7:0
- Sub-module apa102_word_shifter:
  - 32-bit load, bit-count input, CLK_DIV phase counter.
  - Drives spi_sck/spi_mosi and pulses word_done.
  - The FSM in apa102_frame_streamer sequences it.

Test Plan:
1. Reset check: NUM_LEDS=2, CLK_DIV=1, assert rst_n=0 → all outputs 0. Release with no start → no SCK edges for 100 cycles.
2. Basic frame: RAM[0]=24'hFF0000, RAM[1]=24'h0000FF, BRIGHTNESS=31, pulse start → bytes captured on SCK rising edges are 00 00 00 00, FF 00 00 FF, FF FF 00 00, FF FF FF FF. done occurs 1+256+4=261 cycles after start; busy low after.
3. Address/latency check: NUM_LEDS=4, RAM[i]=24'h010203*(i+1) → ram_address sequence 0,1,2,3 each held 1 cycle in FETCH_ADDR. LED k bytes are E0|1F, 03*(k+1), 02*(k+1), 01*(k+1).
4. Start while busy: pulse start at mid-LED-frame and on the done cycle → exactly one frame emitted, then one more frame only for a start 1 cycle after done.
5. Reset mid-frame: drop rst_n during LED 1 → spi_sck=0 and busy=0 immediately, no done pulse. A new start yields a full correct frame.
6. With APA102_RUNTIME_BRIGHTNESS_EN: brightness=5'd3 at start, changed to 5'd31 mid-frame → every LED header byte is 8'hE3.
